// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, port IDs and counter width.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_wait_counter.sv
// Wait-state counter: cleared by load, advances while enabled, holds at and flags the terminal count.
module dmem_wait_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (C) and the debug/loader port (D),
// sequencing each access over a fixed number of wait states and stalling the CPU until its own done.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_MAX   = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    port_e             grant_q, grant_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cnt_load, cnt_en, cnt_tc;

    dmem_wait_counter #(
        .W(CNT_W)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .limit_i(WAIT_MAX),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = starve_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_load = 1'b1;
                if (!dbg_req) begin
                    starve_d = '0;
                end
                if (cpu_req || dbg_req) begin
                    state_d = ST_ACCESS;
                    // D wins when alone, or when C has been granted STARVE_LIMIT times in a row over it
                    if (dbg_req && (!cpu_req || starve_q == STARVE_MAX)) begin
                        grant_d  = PORT_D;
                        we_d     = dbg_we;
                        addr_d   = dbg_addr;
                        wdata_d  = dbg_wdata;
                        starve_d = '0;
                    end else begin
                        grant_d = PORT_C;
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        if (dbg_req) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= PORT_C;
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_done  = (state_q == ST_DONE) && (grant_q == PORT_C);
    assign dbg_done  = (state_q == ST_DONE) && (grant_q == PORT_D);
    assign cpu_rdata = rdata_q;
    assign dbg_rdata = rdata_q;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a transaction-level model predicts each completion,
// a negedge monitor compares every done pulse and the per-cycle memory/stall outputs.
module tb_dmem_port_arbiter;

    localparam int WC = 1;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, cpu_stall, dbg_done, mem_en, mem_we;

    dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (i == 20) ? 32'h0000_0007 : (32'hC0DE_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h40 + (32'($urandom_range(0, 15)) << 2);
    endfunction

    // Bench memory: combinational read, write on the clock edge while enabled
    logic [31:0] bmem [64];
    assign mem_rdata = bmem[mem_addr[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) bmem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) bmem[mem_addr[7:2]] = mem_wdata;
        end
    end

    // Reference model
    typedef struct {
        bit          port_d;
        bit          we;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    bit          done_log[$];
    bit          model_en = 1'b0;
    int          cyc = 0;
    int          busy = 0;
    int          starve = 0;
    int          acc_start = 1, acc_end = 0;
    bit          e_we;
    logic [31:0] e_addr, e_wdata;
    logic [31:0] ref_mem [64];

    initial begin
        bit          win_d;
        logic [31:0] a, wd;
        exp_t        e;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (model_en && rst) begin
                if (busy > 0) begin
                    busy--;
                end else begin
                    if (!dbg_req) starve = 0;
                    if (cpu_req || dbg_req) begin
                        win_d = dbg_req && (!cpu_req || starve == SL);
                        e.port_d = win_d;
                        e.we     = win_d ? dbg_we : cpu_we;
                        a        = win_d ? dbg_addr : cpu_addr;
                        wd       = win_d ? dbg_wdata : cpu_wdata;
                        e.rd     = ref_mem[a[7:2]];
                        if (e.we) ref_mem[a[7:2]] = wd;
                        e.cyc    = cyc + WC + 2;
                        exp_q.push_back(e);
                        acc_start = cyc + 1;
                        acc_end   = cyc + WC + 1;
                        e_we = e.we; e_addr = a; e_wdata = wd;
                        busy = WC + 2;
                        if (win_d) starve = 0;
                        else if (dbg_req) starve = (starve < SL) ? starve + 1 : SL;
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        bit   exp_en, exp_cdone;
        forever begin
            @(negedge clk);
            if (model_en && rst) begin
                chk("no_x", 32'($isunknown({cpu_rdata, cpu_done, cpu_stall, dbg_rdata, dbg_done,
                                             mem_en, mem_we, mem_addr, mem_wdata})), 32'd0);
                exp_en = (cyc >= acc_start) && (cyc <= acc_end);
                chk("mem_en", 32'(mem_en), 32'(exp_en));
                if (exp_en) begin
                    chk("mem_we", 32'(mem_we), 32'(e_we));
                    chk("mem_addr", mem_addr, e_addr);
                    if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
                end
                exp_cdone = (exp_q.size() > 0) && (exp_q[0].cyc == cyc) && !exp_q[0].port_d;
                chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !exp_cdone));
                if (cpu_done || dbg_done) begin
                    if (exp_q.size() == 0) begin
                        fail("done_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_port", 32'({cpu_done, dbg_done}), e.port_d ? 32'd1 : 32'd2);
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                        if (!e.we) chk("rdata", e.port_d ? dbg_rdata : cpu_rdata, e.rd);
                        done_log.push_back(dbg_done);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    fail("done_missing");
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue_c(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        int n = 0;
        cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        do begin @(negedge clk); n++; end while (!cpu_done && n < 100);
        if (!cpu_done) fail("cpu_timeout");
        rd  = cpu_rdata;
        lat = n - 1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        int n = 0;
        dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
        do begin @(negedge clk); n++; end while (!dbg_done && n < 100);
        if (!dbg_done) fail("dbg_timeout");
        rd  = dbg_rdata;
        lat = n - 1;
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd_c, rd_d;
    int          lat_c, lat_d;
    bit          exp_order [5];

    initial begin
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values, stall follows cpu_req even in reset
        #3;
        chk("rst_flags", 32'({mem_en, mem_we, cpu_done, dbg_done, cpu_stall}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        cpu_req = 1'b1; #1;
        chk("rst_stall_follows_req", 32'(cpu_stall), 32'd1);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // Reset while a debug write is in its first ACCESS cycle
        @(posedge clk); #1;
        dbg_we = 1'b1; dbg_addr = 32'h60; dbg_wdata = 32'hDEAD_BEEF; dbg_req = 1'b1;
        @(posedge clk); #1;
        chk("midrst_access_en", 32'(mem_en), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_en_dropped", 32'(mem_en), 32'd0);
        dbg_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_done", 32'({dbg_done, mem_en}), 32'd0);
        end
        chk("midrst_mem_untouched", bmem[24], init_val(24));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'({mem_en, dbg_done, cpu_done}), 32'd0);
        model_en = 1'b1;

        // CPU load from preloaded word
        issue_c(1'b0, 32'h50, 32'h0, rd_c, lat_c);
        chk("lw_rdata", rd_c, 32'h0000_0007);
        chk("lw_latency", 32'(lat_c), 32'(WC + 2));

        // CPU store then debug readback
        issue_c(1'b1, 32'h54, 32'h0000_0015, rd_c, lat_c);
        issue_d(1'b0, 32'h54, 32'h0, rd_d, lat_d);
        chk("sw_readback", rd_d, 32'h0000_0015);
        chk("dbg_latency", 32'(lat_d), 32'(WC + 2));

        // Both ports contend: C four times, then D forced
        done_log.delete();
        fork
            for (int k = 0; k < 5; k++) issue_c(1'b0, 32'h48, 32'h0, rd_c, lat_c);
            issue_d(1'b0, 32'h58, 32'h0, rd_d, lat_d);
        join
        if (done_log.size() < 5) fail("starve_order_len");
        else for (int k = 0; k < 5; k++) chk("starve_order", 32'(done_log[k]), 32'(exp_order[k]));

        // CPU arriving one cycle behind a debug access stays stalled
        fork
            issue_d(1'b0, 32'h58, 32'h0, rd_d, lat_d);
            begin
                @(posedge clk); #1;
                issue_c(1'b0, 32'h50, 32'h0, rd_c, lat_c);
            end
        join
        chk("blocked_cpu_latency", 32'(lat_c), 32'(2 * WC + 4));

        // Debug request dropped right after grant still completes
        dbg_we = 1'b0; dbg_addr = 32'h54; dbg_req = 1'b1;
        @(posedge clk); #1 dbg_req = 1'b0;
        repeat (WC + 3) @(posedge clk);
        #1;

        // Randomized traffic on both ports
        fork
            for (int k = 0; k < 120; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                issue_c(1'($urandom_range(0, 1)), rand_addr(), $urandom, rd_c, lat_c);
            end
            for (int k = 0; k < 80; k++) begin
                repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
                issue_d(1'($urandom_range(0, 1)), rand_addr(), $urandom, rd_d, lat_d);
            end
        join

        repeat (WC + 6) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
